// File: rtl/img_sram_pkg.sv
// img_sram_pkg: shared types and constants for the image-buffer subsystem.
// Provides the SRAM control bundle, the two-state controller enum, the idle
// control value, and the clamped pixel-count helper used by both controllers.
package img_sram_pkg;

   localparam int IMG_MAX_DIM     = 128;
   localparam int IMG_ADDR_W      = 14;
   localparam int IMG_BANK_ADDR_W = 12;
   localparam int IMG_CNT_W       = IMG_ADDR_W + 1;

   typedef struct packed {
      logic                  csb;
      logic                  web;
      logic [IMG_ADDR_W-1:0] addr;
      logic [7:0]            din;
   } img_sram_ctrl_t;

   typedef enum logic {CTRL_IDLE, CTRL_RUN} ctrl_state_t;

   localparam img_sram_ctrl_t IMG_CTRL_IDLE = '{csb: 1'b1, web: 1'b1, addr: '0, din: '0};

   // Each dimension saturates at max_dim so an oversized request still fits
   // the buffer; the count needs one bit more than the address (128*128).
   function automatic logic [IMG_CNT_W-1:0] img_pixel_count(input logic [7:0] rows,
                                                            input logic [7:0] cols,
                                                            input int         max_dim);
      logic [7:0] r;
      logic [7:0] c;
      r = (int'(rows) > max_dim) ? 8'(max_dim) : rows;
      c = (int'(cols) > max_dim) ? 8'(max_dim) : cols;
      return IMG_CNT_W'(r) * IMG_CNT_W'(c);
   endfunction

endpackage

// File: rtl/img_sram_4_64.sv
// img_sram_4_64: 16 KiB image SRAM built from NBANKS img_sram_bank instances.
// Ports: clk, rstn, ctrl (csb/web/addr[13:0]/din), dout[7:0] read data.
// addr[13:12] picks the bank, addr[11:0] the word within it.
module img_sram_4_64
   import img_sram_pkg::*;
#(
   parameter int NBANKS = 4
) (
   input  logic           clk,
   input  logic           rstn,
   input  img_sram_ctrl_t ctrl,
   output logic [7:0]     dout
);

   localparam int SEL_W = IMG_ADDR_W - IMG_BANK_ADDR_W;

   logic [SEL_W-1:0] bank_sel;
   logic [SEL_W-1:0] bank_q;
   logic [7:0]       bank_dout [NBANKS];

   assign bank_sel = ctrl.addr[IMG_ADDR_W-1:IMG_BANK_ADDR_W];

   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      img_sram_bank u_bank (
         .clk  (clk),
         .rstn (rstn),
         .csb  (ctrl.csb | (bank_sel != SEL_W'(b))),
         .web  (ctrl.web),
         .addr (ctrl.addr[IMG_BANK_ADDR_W-1:0]),
         .din  (ctrl.din),
         .dout (bank_dout[b])
      );
   end

   // The bank index is delayed to line up with the one-cycle read latency;
   // it only follows reads so the muxed output holds like a single SRAM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bank_q <= '0;
      end else if (!ctrl.csb && ctrl.web) begin
         bank_q <= bank_sel;
      end
   end

   assign dout = bank_dout[bank_q];

endmodule

// File: rtl/img_sram_bank.sv
// img_sram_bank: one 4096x8 synchronous single-port SRAM bank.
// Ports: clk, rstn (clears only the read-data register), csb/web (active-low
// select and write enable), addr[11:0], din[7:0], dout[7:0] (1-cycle read).
// The storage array itself has no reset and survives rstn.
module img_sram_bank
   import img_sram_pkg::*;
(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       csb,
   input  logic                       web,
   input  logic [IMG_BANK_ADDR_W-1:0] addr,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout
);

   logic [7:0] mem [0:(1<<IMG_BANK_ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (!csb && !web) begin
         mem[addr] <= din;
      end
   end

   // Read data only moves on a selected read, so dout holds otherwise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout <= '0;
      end else if (!csb && web) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/io_rx_controller.sv
// io_rx_controller: writes a raster-order pixel stream into the image SRAM.
// Ports: clk, rstn, rx_en (start pulse), nrows/ncols (sampled at start),
// din (pixel), ctrl (registered SRAM write request), busy.
// The start edge already captures pixel 0; one pixel per cycle follows.
module io_rx_controller
   import img_sram_pkg::*;
#(
   parameter int MAX_DIM = IMG_MAX_DIM
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           rx_en,
   input  logic [7:0]     nrows,
   input  logic [7:0]     ncols,
   input  logic [7:0]     din,
   output img_sram_ctrl_t ctrl,
   output logic           busy
);

   ctrl_state_t          state, state_d;
   logic [IMG_CNT_W-1:0] n_q, n_d, idx_q, idx_d, n_start;
   img_sram_ctrl_t       ctrl_d;

   assign n_start = img_pixel_count(nrows, ncols, MAX_DIM);
   assign busy    = (state == CTRL_RUN);

   // idx counts pixels already registered; once it reaches N the final
   // write is on the bus this cycle and the controller releases the SRAM.
   always_comb begin
      state_d = state;
      n_d     = n_q;
      idx_d   = idx_q;
      ctrl_d  = ctrl;
      case (state)
         CTRL_IDLE: begin
            if (rx_en && (n_start != '0)) begin
               state_d = CTRL_RUN;
               n_d     = n_start;
               idx_d   = IMG_CNT_W'(1);
               ctrl_d  = '{csb: 1'b0, web: 1'b0, addr: '0, din: din};
            end
         end
         CTRL_RUN: begin
            if (idx_q == n_q) begin
               state_d = CTRL_IDLE;
               idx_d   = '0;
               ctrl_d  = IMG_CTRL_IDLE;
            end else begin
               idx_d       = idx_q + 1'b1;
               ctrl_d.addr = idx_q[IMG_ADDR_W-1:0];
               ctrl_d.din  = din;
            end
         end
         default: state_d = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= CTRL_IDLE;
         n_q   <= '0;
         idx_q <= '0;
         ctrl  <= IMG_CTRL_IDLE;
      end else begin
         state <= state_d;
         n_q   <= n_d;
         idx_q <= idx_d;
         ctrl  <= ctrl_d;
      end
   end

endmodule

// File: rtl/io_tx_controller.sv
// io_tx_controller: streams the stored image back out of the SRAM.
// Ports: clk, rstn, tx_en (start pulse), nrows/ncols (sampled at start),
// ctrl (registered SRAM read request), rdata (SRAM read data), dout, busy.
// Build option IMG_TX_DOUT_REG_EN registers dout, adding one cycle of
// latency; busy is then stretched one cycle to cover the last pixel.
module io_tx_controller
   import img_sram_pkg::*;
#(
   parameter int MAX_DIM = IMG_MAX_DIM
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           tx_en,
   input  logic [7:0]     nrows,
   input  logic [7:0]     ncols,
   output img_sram_ctrl_t ctrl,
   input  logic [7:0]     rdata,
   output logic [7:0]     dout,
   output logic           busy
);

   ctrl_state_t          state, state_d;
   logic [IMG_CNT_W-1:0] n_q, n_d, idx_q, idx_d, n_start;
   img_sram_ctrl_t       ctrl_d;
   logic                 running;

   assign n_start = img_pixel_count(nrows, ncols, MAX_DIM);
   assign running = (state == CTRL_RUN);

   // Same sequencing as the receive side, issuing reads instead of writes.
   always_comb begin
      state_d = state;
      n_d     = n_q;
      idx_d   = idx_q;
      ctrl_d  = ctrl;
      case (state)
         CTRL_IDLE: begin
            if (tx_en && !busy && (n_start != '0)) begin
               state_d = CTRL_RUN;
               n_d     = n_start;
               idx_d   = IMG_CNT_W'(1);
               ctrl_d  = '{csb: 1'b0, web: 1'b1, addr: '0, din: '0};
            end
         end
         CTRL_RUN: begin
            if (idx_q == n_q) begin
               state_d = CTRL_IDLE;
               idx_d   = '0;
               ctrl_d  = IMG_CTRL_IDLE;
            end else begin
               idx_d       = idx_q + 1'b1;
               ctrl_d.addr = idx_q[IMG_ADDR_W-1:0];
            end
         end
         default: state_d = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= CTRL_IDLE;
         n_q   <= '0;
         idx_q <= '0;
         ctrl  <= IMG_CTRL_IDLE;
      end else begin
         state <= state_d;
         n_q   <= n_d;
         idx_q <= idx_d;
         ctrl  <= ctrl_d;
      end
   end

`ifdef IMG_TX_DOUT_REG_EN
   logic [7:0] dout_q;
   logic       tail_q;

   // tail_q covers the extra cycle the last pixel spends in the output register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout_q <= '0;
         tail_q <= 1'b0;
      end else begin
         dout_q <= rdata;
         tail_q <= running && (state_d == CTRL_IDLE);
      end
   end

   assign dout = dout_q;
   assign busy = running | tail_q;
`else
   assign dout = rdata;
   assign busy = running;
`endif

endmodule

// File: rtl/img_sram_io.sv
// img_sram_io: image-buffer subsystem top level.
// Ports: clk, rstn (async active-low), rx_en/tx_en start pulses, sram_sel_rx
// (1: rx owns the SRAM, 0: tx), nrows/ncols image size, din pixel in,
// dout pixel out, rx_busy/tx_busy.
// Build option IMG_TX_DOUT_REG_EN adds a register on dout (see io_tx_controller).
module img_sram_io
   import img_sram_pkg::*;
#(
   parameter int MAX_DIM = IMG_MAX_DIM,
   parameter int NBANKS  = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_en,
   input  logic       tx_en,
   input  logic       sram_sel_rx,
   input  logic [7:0] nrows,
   input  logic [7:0] ncols,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       rx_busy,
   output logic       tx_busy
);

   img_sram_ctrl_t rx_ctrl;
   img_sram_ctrl_t tx_ctrl;
   img_sram_ctrl_t sram_ctrl;
   logic [7:0]     sram_dout;

   io_rx_controller #(.MAX_DIM(MAX_DIM)) u_rx (
      .clk   (clk),
      .rstn  (rstn),
      .rx_en (rx_en),
      .nrows (nrows),
      .ncols (ncols),
      .din   (din),
      .ctrl  (rx_ctrl),
      .busy  (rx_busy)
   );

   io_tx_controller #(.MAX_DIM(MAX_DIM)) u_tx (
      .clk   (clk),
      .rstn  (rstn),
      .tx_en (tx_en),
      .nrows (nrows),
      .ncols (ncols),
      .ctrl  (tx_ctrl),
      .rdata (sram_dout),
      .dout  (dout),
      .busy  (tx_busy)
   );

   // Only the selected controller reaches the SRAM; the other runs unheard.
   assign sram_ctrl = sram_sel_rx ? rx_ctrl : tx_ctrl;

   img_sram_4_64 #(.NBANKS(NBANKS)) u_sram (
      .clk  (clk),
      .rstn (rstn),
      .ctrl (sram_ctrl),
      .dout (sram_dout)
   );

endmodule

// File: tb/tb_img_sram_io.sv
// tb_img_sram_io: directed self-checking bench for img_sram_io.
// Keeps its own image model (exp_img) and logs every SRAM access seen on
// the top-level control bus to check addresses and access counts.
module tb_img_sram_io;

`ifdef IMG_TX_DOUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk, rstn, rx_en, tx_en, sram_sel_rx;
   logic [7:0] nrows, ncols, din, dout;
   logic       rx_busy, tx_busy;

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  exp_img [16384];
   int unsigned acc_count = 0;
   int          wr_log [$];

   img_sram_io dut (
      .clk         (clk),
      .rstn        (rstn),
      .rx_en       (rx_en),
      .tx_en       (tx_en),
      .sram_sel_rx (sram_sel_rx),
      .nrows       (nrows),
      .ncols       (ncols),
      .din         (din),
      .dout        (dout),
      .rx_busy     (rx_busy),
      .tx_busy     (tx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Log what the SRAM actually sees at each edge.
   always @(posedge clk) begin
      if (dut.sram_ctrl.csb == 1'b0) begin
         acc_count++;
         if (dut.sram_ctrl.web == 1'b0) wr_log.push_back(int'(dut.sram_ctrl.addr));
      end
   end

   function automatic logic [7:0] pix(input int i, input int seed);
      return 8'((i + 1) * seed + (i >> 7) * 3);
   endfunction

   function automatic int pixel_total(input int rows, input int cols);
      int r;
      int c;
      r = (rows > 128) ? 128 : rows;
      c = (cols > 128) ? 128 : cols;
      return r * c;
   endfunction

   function automatic int wr_at(input int idx);
      return (idx < wr_log.size()) ? wr_log[idx] : -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Receive one image; optionally re-pulse rx_en (with a bigger size) mid-run.
   task automatic apply_stimulus(input int rows, input int cols, input int seed,
                                 input int repulse_at, output int cycles);
      int n;
      n = pixel_total(rows, cols);
      sram_sel_rx = 1'b1;
      nrows = 8'(rows);
      ncols = 8'(cols);
      din   = pix(0, seed);
      rx_en = 1'b1;
      tick();
      rx_en  = 1'b0;
      cycles = 0;
      while (rx_busy === 1'b1 && cycles < 20000) begin
         cycles++;
         din = pix(cycles, seed);
         if (cycles == repulse_at) begin
            rx_en = 1'b1;
            nrows = 8'd8;
            ncols = 8'd8;
         end else begin
            rx_en = 1'b0;
         end
         tick();
      end
      rx_en = 1'b0;
      for (int i = 0; i < n; i++) exp_img[i] = pix(i, seed);
   endtask

   // Transmit one image and compare dout/tx_busy cycle by cycle to the model.
   task automatic run_tx(input int rows, input int cols, output int data_errs,
                         output int busy_errs, output int busy_cycles);
      int n;
      n = pixel_total(rows, cols);
      data_errs   = 0;
      busy_errs   = 0;
      busy_cycles = 0;
      sram_sel_rx = 1'b0;
      nrows = 8'(rows);
      ncols = 8'(cols);
      tx_en = 1'b1;
      tick();
      tx_en = 1'b0;
      if (tx_busy === 1'b1) busy_cycles++;
      for (int j = 1; j < LAT; j++) begin
         tick();
         if (tx_busy === 1'b1) busy_cycles++;
      end
      for (int i = 0; i < n; i++) begin
         tick();
         if (tx_busy === 1'b1) busy_cycles++;
         if (dout !== exp_img[i]) begin
            if (data_errs < 5) $display("[TB] pixel %0d: got %h want %h", i, dout, exp_img[i]);
            data_errs++;
         end
         if (tx_busy !== (i < n - 1)) busy_errs++;
      end
      tick();
      if (tx_busy === 1'b1) busy_cycles++;
   endtask

   initial begin
      int cyc, base, de, be, bc, addr_errs;
      int unsigned acc_base;

      rstn = 1'b0; rx_en = 1'b0; tx_en = 1'b0; sram_sel_rx = 1'b1;
      nrows = '0; ncols = '0; din = '0;
      #12;
      check_output("reset rx_busy", 32'(rx_busy), 0);
      check_output("reset tx_busy", 32'(tx_busy), 0);
      check_output("reset dout", 32'(dout), 0);
      rstn = 1'b1;
      tick();
      tick();

      $display("[TB] loopback 128x128");
      base = wr_log.size();
      apply_stimulus(128, 128, 37, -1, cyc);
      check_output("loop rx busy cycles", cyc, 16384);
      check_output("loop write count", wr_log.size() - base, 16384);
      check_output("loop first wr addr", wr_at(base), 0);
      check_output("loop last wr addr", wr_at(base + 16383), 16383);
      run_tx(128, 128, de, be, bc);
      check_output("loop tx data errors", de, 0);
      check_output("loop tx busy shape errors", be, 0);
      check_output("loop tx busy cycles", bc, 16384 + LAT - 1);

      $display("[TB] 3x5 image");
      base = wr_log.size();
      apply_stimulus(3, 5, 1, -1, cyc);
      check_output("3x5 rx busy cycles", cyc, 15);
      check_output("3x5 write count", wr_log.size() - base, 15);
      addr_errs = 0;
      for (int i = 0; i < 15; i++) if (wr_at(base + i) != i) addr_errs++;
      check_output("3x5 write addr errors", addr_errs, 0);
      run_tx(3, 5, de, be, bc);
      check_output("3x5 tx data errors", de, 0);
      check_output("3x5 tx busy shape errors", be, 0);
      check_output("3x5 tx busy cycles", bc, 15 + LAT - 1);

      $display("[TB] zero rows");
      acc_base = acc_count;
      sram_sel_rx = 1'b1; nrows = 8'd0; ncols = 8'd5; rx_en = 1'b1;
      tick();
      rx_en = 1'b0;
      check_output("zero rx_busy", 32'(rx_busy), 0);
      tick(); tick();
      sram_sel_rx = 1'b0; tx_en = 1'b1;
      tick();
      tx_en = 1'b0;
      check_output("zero tx_busy", 32'(tx_busy), 0);
      tick(); tick();
      check_output("zero sram accesses", acc_count - acc_base, 0);

      $display("[TB] second rx_en while busy");
      base = wr_log.size();
      apply_stimulus(4, 4, 55, 5, cyc);
      check_output("repulse rx busy cycles", cyc, 16);
      check_output("repulse write count", wr_log.size() - base, 16);
      run_tx(4, 4, de, be, bc);
      check_output("repulse tx data errors", de, 0);

      $display("[TB] reset during receive");
      base = wr_log.size();
      sram_sel_rx = 1'b1; nrows = 8'd128; ncols = 8'd128;
      din = pix(0, 91); rx_en = 1'b1;
      tick();
      rx_en = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         din = pix(i, 91);
         tick();
      end
      rstn = 1'b0;
      #1;
      check_output("midreset rx_busy", 32'(rx_busy), 0);
      check_output("midreset tx_busy", 32'(tx_busy), 0);
      check_output("midreset dout", 32'(dout), 0);
      check_output("midreset write count", wr_log.size() - base, 100);
      for (int i = 0; i < 100; i++) exp_img[i] = pix(i, 91);
      #2;
      rstn = 1'b1;
      tick();
      base = wr_log.size();
      apply_stimulus(2, 2, 200, -1, cyc);
      check_output("restart rx busy cycles", cyc, 4);
      check_output("restart write count", wr_log.size() - base, 4);
      check_output("restart first wr addr", wr_at(base), 0);
      run_tx(1, 128, de, be, bc);
      check_output("retained data errors", de, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
